// File: rtl/sram_bist_pkg.sv
// Shared types and helpers for the dual-port-pair SRAM BIST controller.
package sram_bist_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int PAIR_COUNT = 128;
  localparam int PAIR_W     = 7;
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(PAIR_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_BG  = 3'd1,
    RD_BG  = 3'd2,
    WR_INV = 3'd3,
    RD_INV = 3'd4,
    DONE   = 3'd5
  } bist_state_e;

  // Word expected at an address: address replicated across the word, XORed
  // with the background, optionally complemented for the inverse phases.
  function automatic logic [DATA_W-1:0] bist_pattern(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] bg,
    input logic              inv
  );
    logic [DATA_W-1:0] p;
    p = {4{addr}} ^ bg;
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/sram_bist_checker.sv
// Dual-lane read-data checker: one-cycle-delayed compare of ports C/D and
// first-fail capture with port C (lower address) taking priority.
module sram_bist_checker
  import sram_bist_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_issue,
  input  logic [ADDR_W-1:0] i_addr_c,
  input  logic [DATA_W-1:0] i_exp_c,
  input  logic [DATA_W-1:0] i_exp_d,
  input  logic [DATA_W-1:0] i_data_c,
  input  logic [DATA_W-1:0] i_data_d,
  output logic              o_fail,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [DATA_W-1:0] o_fail_data
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr_c;
  logic [DATA_W-1:0] r_exp_c;
  logic [DATA_W-1:0] r_exp_d;
  logic              r_fail;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [DATA_W-1:0] r_fail_data;

  logic              w_mis_c;
  logic              w_mis_d;
  logic [ADDR_W-1:0] w_addr_d;

  // i_issue marks the cycle a read pair goes out; r_valid qualifies the
  // returned data exactly one cycle later, there is no back-pressure.
  assign w_addr_d = {r_addr_c[ADDR_W-1:1], 1'b1};
  assign w_mis_c  = r_valid && (i_data_c != r_exp_c);
  assign w_mis_d  = r_valid && (i_data_d != r_exp_d);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid     <= 1'b0;
      r_addr_c    <= '0;
      r_exp_c     <= '0;
      r_exp_d     <= '0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_valid  <= i_issue;
      r_addr_c <= i_addr_c;
      r_exp_c  <= i_exp_c;
      r_exp_d  <= i_exp_d;
      if (i_clear) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_data <= '0;
      end else if (!r_fail && (w_mis_c || w_mis_d)) begin
        r_fail      <= 1'b1;
        r_fail_addr <= w_mis_c ? r_addr_c : w_addr_d;
        r_fail_data <= w_mis_c ? i_data_c : i_data_d;
      end
    end
  end

  assign o_fail      = r_fail;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_data = r_fail_data;

endmodule

// File: rtl/sram_bist_controller.sv
// SRAM BIST sequencer: background/inverse write-read march over address pairs.
// Optional macro BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module sram_bist_controller
  import sram_bist_pkg::*;
#(
  parameter logic [31:0] BACKGROUND = 32'hA5A5_5A5A
) (
  input  logic        Clk_In,
  input  logic        Reset_In,
  input  logic        Start_In,
  output logic        Busy_Out,
  output logic        Done_Out,
  output logic        Fail_Out,
  output logic [7:0]  Fail_Address_Out,
  output logic [31:0] Fail_Data_Out,
  output logic [31:0] Port_W_A_Data_Out,
  output logic [7:0]  Port_W_A_Address_Out,
  output logic        Port_W_A_Write_Enable_Out,
  output logic [31:0] Port_W_B_Data_Out,
  output logic [7:0]  Port_W_B_Address_Out,
  output logic        Port_W_B_Write_Enable_Out,
  output logic [7:0]  Port_R_C_Address_Out,
  output logic        Port_R_C_Read_Enable_Out,
  input  logic [31:0] Port_R_C_Data_In,
  output logic [7:0]  Port_R_D_Address_Out,
  output logic        Port_R_D_Read_Enable_Out,
  input  logic [31:0] Port_R_D_Data_In,
  output logic [2:0]  Dbg_State_Out
);

  bist_state_e       r_state;
  logic [PAIR_W-1:0] r_k;
  logic              r_drain;
  logic              r_busy;
  logic              r_done;
  logic              r_we_a;
  logic              r_we_b;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic [DATA_W-1:0] r_data_a;
  logic [DATA_W-1:0] r_data_b;
  logic              r_re_c;
  logic              r_re_d;
  logic [ADDR_W-1:0] r_addr_c;
  logic [ADDR_W-1:0] r_addr_d;

  bist_state_e       w_state_nxt;
  logic [PAIR_W-1:0] w_k_nxt;
  logic              w_drain_nxt;
  logic              w_clear;
  logic              w_wr;
  logic              w_rd;
  logic              w_inv;
  logic              w_busy_nxt;
  logic [ADDR_W-1:0] w_addr_even;
  logic [ADDR_W-1:0] w_addr_odd;
  logic [DATA_W-1:0] w_pat_even;
  logic [DATA_W-1:0] w_pat_odd;
  logic              w_fail;

  // Registers hold what is presented to the SRAM this cycle; the next-state
  // logic below therefore also computes the next cycle's port values.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_drain_nxt = r_drain;
    w_clear     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (Start_In) begin
          w_state_nxt = WR_BG;
          w_k_nxt     = '0;
          w_drain_nxt = 1'b0;
          w_clear     = 1'b1;
        end
      end
      WR_BG, WR_INV: begin
        if (r_k == LAST_PAIR) begin
          w_state_nxt = (r_state == WR_BG) ? RD_BG : RD_INV;
          w_k_nxt     = '0;
        end else begin
          w_k_nxt = r_k + 7'd1;
        end
      end
      RD_BG, RD_INV: begin
        if (r_drain) begin
          w_state_nxt = (r_state == RD_BG) ? WR_INV : DONE;
          w_k_nxt     = '0;
          w_drain_nxt = 1'b0;
        end else if (r_k == LAST_PAIR) begin
          w_drain_nxt = 1'b1;
        end else begin
          w_k_nxt = r_k + 7'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_k_nxt     = '0;
        w_drain_nxt = 1'b0;
      end
    endcase
`ifdef BIST_STOP_ON_FAIL_EN
    if (r_busy && w_fail) begin
      w_state_nxt = DONE;
      w_k_nxt     = '0;
      w_drain_nxt = 1'b0;
    end
`endif
  end

  always_comb begin
    w_wr        = (w_state_nxt == WR_BG) || (w_state_nxt == WR_INV);
    w_rd        = ((w_state_nxt == RD_BG) || (w_state_nxt == RD_INV)) && !w_drain_nxt;
    w_inv       = (w_state_nxt == WR_INV) || (w_state_nxt == RD_INV);
    w_busy_nxt  = (w_state_nxt != IDLE) && (w_state_nxt != DONE);
    w_addr_even = {w_k_nxt, 1'b0};
    w_addr_odd  = {w_k_nxt, 1'b1};
    w_pat_even  = bist_pattern(w_addr_even, BACKGROUND, w_inv);
    w_pat_odd   = bist_pattern(w_addr_odd, BACKGROUND, w_inv);
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      r_state  <= IDLE;
      r_k      <= '0;
      r_drain  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_we_a   <= 1'b0;
      r_we_b   <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_data_a <= '0;
      r_data_b <= '0;
      r_re_c   <= 1'b0;
      r_re_d   <= 1'b0;
      r_addr_c <= '0;
      r_addr_d <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_k      <= w_k_nxt;
      r_drain  <= w_drain_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= (w_state_nxt == DONE);
      r_we_a   <= w_wr;
      r_we_b   <= w_wr;
      r_addr_a <= w_wr ? w_addr_even : '0;
      r_addr_b <= w_wr ? w_addr_odd  : '0;
      r_data_a <= w_wr ? w_pat_even  : '0;
      r_data_b <= w_wr ? w_pat_odd   : '0;
      r_re_c   <= w_rd;
      r_re_d   <= w_rd;
      r_addr_c <= w_rd ? w_addr_even : '0;
      r_addr_d <= w_rd ? w_addr_odd  : '0;
    end
  end

  sram_bist_checker u_checker (
    .i_clk       (Clk_In),
    .i_rst       (Reset_In),
    .i_clear     (w_clear),
    .i_issue     (w_rd),
    .i_addr_c    (w_rd ? w_addr_even : 8'h00),
    .i_exp_c     (w_rd ? w_pat_even : 32'h0),
    .i_exp_d     (w_rd ? w_pat_odd : 32'h0),
    .i_data_c    (Port_R_C_Data_In),
    .i_data_d    (Port_R_D_Data_In),
    .o_fail      (w_fail),
    .o_fail_addr (Fail_Address_Out),
    .o_fail_data (Fail_Data_Out)
  );

  assign Busy_Out                  = r_busy;
  assign Done_Out                  = r_done;
  assign Fail_Out                  = w_fail;
  assign Port_W_A_Data_Out         = r_data_a;
  assign Port_W_A_Address_Out      = r_addr_a;
  assign Port_W_A_Write_Enable_Out = r_we_a;
  assign Port_W_B_Data_Out         = r_data_b;
  assign Port_W_B_Address_Out      = r_addr_b;
  assign Port_W_B_Write_Enable_Out = r_we_b;
  assign Port_R_C_Address_Out      = r_addr_c;
  assign Port_R_C_Read_Enable_Out  = r_re_c;
  assign Port_R_D_Address_Out      = r_addr_d;
  assign Port_R_D_Read_Enable_Out  = r_re_d;
  assign Dbg_State_Out             = r_state;

endmodule

// File: tb/tb_sram_bist_controller.sv
// Directed bench for sram_bist_controller with a negedge-sampled SRAM model
// that supports per-address stuck-at-1 (OR) and bit-flip (XOR) faults.
module tb_sram_bist_controller;

  logic        Clk_In = 1'b0;
  logic        Reset_In;
  logic        Start_In;
  logic        Busy_Out, Done_Out, Fail_Out;
  logic [7:0]  Fail_Address_Out;
  logic [31:0] Fail_Data_Out;
  logic [31:0] Port_W_A_Data_Out, Port_W_B_Data_Out;
  logic [7:0]  Port_W_A_Address_Out, Port_W_B_Address_Out;
  logic        Port_W_A_Write_Enable_Out, Port_W_B_Write_Enable_Out;
  logic [7:0]  Port_R_C_Address_Out, Port_R_D_Address_Out;
  logic        Port_R_C_Read_Enable_Out, Port_R_D_Read_Enable_Out;
  logic [31:0] Port_R_C_Data_In, Port_R_D_Data_In;
  logic [2:0]  Dbg_State_Out;

  logic [31:0] mem     [256];
  logic [31:0] flt_or  [256];
  logic [31:0] flt_xor [256];
  int wr_bg_cnt, wr_inv_cnt, port_err;
  int n_cmp, n_mis;
  int done_cyc, fail_cyc;

  sram_bist_controller dut (
    .Clk_In                    (Clk_In),
    .Reset_In                  (Reset_In),
    .Start_In                  (Start_In),
    .Busy_Out                  (Busy_Out),
    .Done_Out                  (Done_Out),
    .Fail_Out                  (Fail_Out),
    .Fail_Address_Out          (Fail_Address_Out),
    .Fail_Data_Out             (Fail_Data_Out),
    .Port_W_A_Data_Out         (Port_W_A_Data_Out),
    .Port_W_A_Address_Out      (Port_W_A_Address_Out),
    .Port_W_A_Write_Enable_Out (Port_W_A_Write_Enable_Out),
    .Port_W_B_Data_Out         (Port_W_B_Data_Out),
    .Port_W_B_Address_Out      (Port_W_B_Address_Out),
    .Port_W_B_Write_Enable_Out (Port_W_B_Write_Enable_Out),
    .Port_R_C_Address_Out      (Port_R_C_Address_Out),
    .Port_R_C_Read_Enable_Out  (Port_R_C_Read_Enable_Out),
    .Port_R_C_Data_In          (Port_R_C_Data_In),
    .Port_R_D_Address_Out      (Port_R_D_Address_Out),
    .Port_R_D_Read_Enable_Out  (Port_R_D_Read_Enable_Out),
    .Port_R_D_Data_In          (Port_R_D_Data_In),
    .Dbg_State_Out             (Dbg_State_Out)
  );

  // Clock and SRAM model: the SRAM samples ports on the falling edge.
  always #5 Clk_In = ~Clk_In;

  always @(negedge Clk_In) begin
    if (Port_W_A_Write_Enable_Out) begin
      mem[Port_W_A_Address_Out] = Port_W_A_Data_Out;
      if (Port_W_A_Address_Out[0] !== 1'b0) port_err++;
      if (Dbg_State_Out == 3'd1) wr_bg_cnt++;
      if (Dbg_State_Out == 3'd3) wr_inv_cnt++;
    end
    if (Port_W_B_Write_Enable_Out) begin
      mem[Port_W_B_Address_Out] = Port_W_B_Data_Out;
      if (Port_W_B_Address_Out[0] !== 1'b1) port_err++;
      if (Dbg_State_Out == 3'd1) wr_bg_cnt++;
      if (Dbg_State_Out == 3'd3) wr_inv_cnt++;
    end
    if (Port_R_C_Read_Enable_Out) begin
      Port_R_C_Data_In = (mem[Port_R_C_Address_Out] | flt_or[Port_R_C_Address_Out])
                         ^ flt_xor[Port_R_C_Address_Out];
      if (Port_R_C_Address_Out[0] !== 1'b0) port_err++;
    end
    if (Port_R_D_Read_Enable_Out) begin
      Port_R_D_Data_In = (mem[Port_R_D_Address_Out] | flt_or[Port_R_D_Address_Out])
                         ^ flt_xor[Port_R_D_Address_Out];
      if (Port_R_D_Address_Out[0] !== 1'b1) port_err++;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge Clk_In);
    #1;
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 256; i++) begin
      flt_or[i]  = '0;
      flt_xor[i] = '0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start pulse sampled at edge 0; counts edges until Done_Out, bounded.
  // pulse_at >= 1 re-asserts Start_In so it is sampled at that edge.
  task automatic run_test(input int pulse_at, output int dcyc, output int fcyc);
    int cyc;
    wr_bg_cnt  = 0;
    wr_inv_cnt = 0;
    port_err   = 0;
    Start_In   = 1'b1;
    tick();
    Start_In   = 1'b0;
    dcyc = -1;
    fcyc = -1;
    cyc  = 0;
    while (cyc < 600 && dcyc < 0) begin
      Start_In = (cyc + 1 == pulse_at);
      tick();
      cyc++;
      if (Fail_Out && fcyc < 0) fcyc = cyc;
      if (Done_Out) dcyc = cyc;
    end
    Start_In = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    wr_bg_cnt = 0;
    wr_inv_cnt = 0;
    port_err = 0;
    Port_R_C_Data_In = '0;
    Port_R_D_Data_In = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    clear_faults();

    // Reset state
    Reset_In = 1'b1;
    Start_In = 1'b0;
    repeat (3) tick();
    Reset_In = 1'b0;
    tick();
    check("rst_busy", {31'd0, Busy_Out}, 32'd0);
    check("rst_done", {31'd0, Done_Out}, 32'd0);
    check("rst_fail", {31'd0, Fail_Out}, 32'd0);
    check("rst_we_a", {31'd0, Port_W_A_Write_Enable_Out}, 32'd0);
    check("rst_re_c", {31'd0, Port_R_C_Read_Enable_Out}, 32'd0);
    check("rst_state", {29'd0, Dbg_State_Out}, 32'd0);

    // Fault-free run
    run_test(-1, done_cyc, fail_cyc);
    check("clean_done_cycle", done_cyc, 514);
    check("clean_fail", {31'd0, Fail_Out}, 32'd0);
    check("clean_wr_bg_cnt", wr_bg_cnt, 256);
    check("clean_wr_inv_cnt", wr_inv_cnt, 256);
    check("clean_port_parity", port_err, 0);
    check("clean_mem_05", mem[5], 32'h5F5F_A0A0);
    check("clean_mem_80", mem[8'h80], 32'hDADA_2525);
    check("clean_busy_at_done", {31'd0, Busy_Out}, 32'd0);
    repeat (3) tick();
    check("done_held", {31'd0, Done_Out}, 32'd1);
    check("done_we_a", {31'd0, Port_W_A_Write_Enable_Out}, 32'd0);
    check("done_addr_c", {24'd0, Port_R_C_Address_Out}, 32'd0);

    // Bit 0 stuck-at-1 at 0x05: P(5)=A0A05F5F already has bit0 set, so the
    // fault surfaces against ~P(5)=5F5FA0A0 in the inverse read phase.
    flt_or[5] = 32'h0000_0001;
    run_test(-1, done_cyc, fail_cyc);
    check("sa1_fail", {31'd0, Fail_Out}, 32'd1);
    check("sa1_addr", {24'd0, Fail_Address_Out}, 32'h05);
    check("sa1_data", Fail_Data_Out, 32'h5F5F_A0A1);
    check("sa1_done", {31'd0, Done_Out}, 32'd1);

    // Start from DONE clears status
    clear_faults();
    Start_In = 1'b1;
    tick();
    Start_In = 1'b0;
    check("restart_fail_clr", {31'd0, Fail_Out}, 32'd0);
    check("restart_addr_clr", {24'd0, Fail_Address_Out}, 32'd0);
    check("restart_data_clr", Fail_Data_Out, 32'd0);
    check("restart_done_clr", {31'd0, Done_Out}, 32'd0);
    check("restart_busy", {31'd0, Busy_Out}, 32'd1);
    check("restart_state", {29'd0, Dbg_State_Out}, 32'd1);
    Reset_In = 1'b1;
    tick();
    Reset_In = 1'b0;
    tick();

    // Same-cycle faults on both lanes: port C (0x10) wins
    flt_xor[8'h10] = 32'h0000_0001;
    flt_xor[8'h11] = 32'h0000_0001;
    run_test(-1, done_cyc, fail_cyc);
    check("dual_addr", {24'd0, Fail_Address_Out}, 32'h10);
    check("dual_data", Fail_Data_Out, 32'hB5B5_4A4B);

    // Odd-lane first fail, later fault does not overwrite
    clear_faults();
    flt_xor[8'h11] = 32'h0000_0001;
    flt_xor[8'h40] = 32'h0000_0100;
    run_test(-1, done_cyc, fail_cyc);
    check("odd_addr", {24'd0, Fail_Address_Out}, 32'h11);
    check("odd_data", Fail_Data_Out, 32'hB4B4_4B4A);

    // Fault at 0x00: detected at edge 129 (pair 0 read at 128)
    clear_faults();
    flt_xor[0] = 32'h0000_0001;
    run_test(-1, done_cyc, fail_cyc);
    check("f00_fail_cycle", fail_cyc, 129);
    check("f00_addr", {24'd0, Fail_Address_Out}, 32'h00);
    check("f00_data", Fail_Data_Out, 32'hA5A5_5A5B);
`ifdef BIST_STOP_ON_FAIL_EN
    check("f00_done_cycle", done_cyc, 130);
`else
    check("f00_done_cycle", done_cyc, 514);
`endif
    check("f00_we_low", {31'd0, Port_W_A_Write_Enable_Out}, 32'd0);
    check("f00_re_low", {31'd0, Port_R_D_Read_Enable_Out}, 32'd0);

    // Reset at edge 200 of a run that already holds a failure
    Start_In = 1'b1;
    tick();
    Start_In = 1'b0;
    repeat (199) tick();
    Reset_In = 1'b1;
    tick();
    check("mid_rst_busy", {31'd0, Busy_Out}, 32'd0);
    check("mid_rst_done", {31'd0, Done_Out}, 32'd0);
    check("mid_rst_fail", {31'd0, Fail_Out}, 32'd0);
    check("mid_rst_faddr", {24'd0, Fail_Address_Out}, 32'd0);
    check("mid_rst_fdata", Fail_Data_Out, 32'd0);
    check("mid_rst_we", {30'd0, Port_W_A_Write_Enable_Out, Port_W_B_Write_Enable_Out}, 32'd0);
    check("mid_rst_re", {30'd0, Port_R_C_Read_Enable_Out, Port_R_D_Read_Enable_Out}, 32'd0);
    check("mid_rst_wdata", Port_W_A_Data_Out | Port_W_B_Data_Out, 32'd0);
    check("mid_rst_state", {29'd0, Dbg_State_Out}, 32'd0);

    // Reset dominates Start on the same edge
    Start_In = 1'b1;
    tick();
    Start_In = 1'b0;
    check("rst_vs_start_state", {29'd0, Dbg_State_Out}, 32'd0);
    check("rst_vs_start_busy", {31'd0, Busy_Out}, 32'd0);
    Reset_In = 1'b0;
    tick();

    // Normal run after reset
    clear_faults();
    run_test(-1, done_cyc, fail_cyc);
    check("post_rst_done_cycle", done_cyc, 514);
    check("post_rst_fail", {31'd0, Fail_Out}, 32'd0);

    // Start pulse at cycle 50 while busy is ignored
    run_test(50, done_cyc, fail_cyc);
    check("busy_start_done_cycle", done_cyc, 514);
    check("busy_start_wr_bg_cnt", wr_bg_cnt, 256);
    check("busy_start_fail", {31'd0, Fail_Out}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
